// File: rtl/trace_commit_sched.sv
// rtl/trace_commit_sched.sv - commit-event filter, FWFT trace FIFO and end-of-run sequencer
// Optional per-record cycle stamp: TRACE_CYCLE_STAMP_EN
`timescale 1ns/1ps
module trace_commit_sched #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = 32'h1c000144,
    parameter int          WE_W   = 4
`ifdef TRACE_CYCLE_STAMP_EN
    , localparam int       REC_W  = 166 + WE_W
`else
    , localparam int       REC_W  = 134 + WE_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    input  logic [31:0]       ev_pc,
    input  logic              ev_rf_en,
    input  logic [4:0]        ev_rf_addr,
    input  logic [31:0]       ev_rf_data,
    input  logic [WE_W-1:0]   ev_ram_we,
    input  logic [31:0]       ev_ram_a,
    input  logic [31:0]       ev_ram_d,
    output logic              ev_stall,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [REC_W-1:0]  tr_data,
    output logic              done,
    output logic [15:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic [REC_W-1:0]  rec;

    logic accept;
    logic recordable;
    logic terminal;
    logic push;
    logic drop;
    logic pop;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_cnt <= '0;
        else if (state != S_DONE)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign rec = {ev_pc, ev_rf_en, ev_rf_addr, ev_rf_data, ev_ram_we, ev_ram_a, ev_ram_d, cycle_cnt};
`else
    assign rec = {ev_pc, ev_rf_en, ev_rf_addr, ev_rf_data, ev_ram_we, ev_ram_a, ev_ram_d};
`endif

    // Stall depends only on registered state, so a same-cycle pop never opens a slot.
    assign ev_stall   = (count == FULL_CNT) || (state != S_RUN);
    assign accept     = ev_valid && !ev_stall;
    assign recordable = (ev_rf_en && (ev_rf_addr != 5'd0)) || (ev_ram_we != '0);
    assign terminal   = accept && (ev_pc == END_PC);
    assign push       = accept && recordable && !terminal;
    assign drop       = accept && !recordable && !terminal;

    assign tr_valid   = (count != '0) && (state != S_DONE);
    assign tr_data    = tr_valid ? mem[rptr] : '0;
    assign pop        = tr_valid && tr_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            done     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (drop && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                S_RUN: begin
                    if (terminal)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule
